// File: rtl/cpu_pkg.sv
// Shared CPU definitions: operand-select codes, register-index width and
// the shadow pipeline stage records used by the forwarding/hazard unit.
package cpu_pkg;

  localparam int REG_AW           = 5;
  localparam int NUM_STAGE_SHADOW = 3;

  localparam logic [1:0] FWD_IDEX  = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  // ID/EX shadow: source indices are kept so forwarding is computed from
  // registered state only.
  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } idex_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } exmem_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              regwrite;
  } memwb_t;

endpackage

// File: rtl/fwd_sel.sv
// Operand-select priority for a single EX-stage operand.
// The newest producer (EX/MEM) wins over the older one (MEM/WB); x0 never
// forwards.
module fwd_sel
  import cpu_pkg::FWD_IDEX;
  import cpu_pkg::FWD_MEMWB;
  import cpu_pkg::FWD_EXMEM;
#(
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_regwrite,
  output logic [1:0]        sel
);

  logic hit_exmem;
  logic hit_memwb;

  assign hit_exmem = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rs);
  assign hit_memwb = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs);

  // Priority encode the two candidate producers.
  always_comb begin
    sel = FWD_IDEX;
    if (hit_exmem) begin
      sel = FWD_EXMEM;
    end else if (hit_memwb) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard control unit. Tracks a shadow copy of the
// destination/control fields through ID/EX, EX/MEM and MEM/WB, produces the
// EX operand-select codes, detects load-use hazards and freezes everything
// while the data cache is missing.
module fwd_hazard_ctrl
  import cpu_pkg::idex_t;
  import cpu_pkg::exmem_t;
  import cpu_pkg::memwb_t;
#(
  // Must match the package width; the shadow records are sized from it.
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  input  logic              mem_stall_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              load_use_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o
);

  idex_t  idex_reg;
  exmem_t exmem_reg;
  memwb_t memwb_reg;
  idex_t  idex_next;

  logic   load_use;
  logic   bubble;

  // Both source fields are treated as used, so a load followed by any
  // instruction naming its rd stalls once.
  assign load_use = idex_reg.memread && (idex_reg.rd != '0) &&
                    ((idex_reg.rd == id_rs1_i) || (idex_reg.rd == id_rs2_i));

  // A pending cache miss freezes the pipeline, so no bubble is inserted
  // until it clears; the load-use hazard is then resolved afterwards.
  assign bubble = (load_use || flush_i) && !mem_stall_i;

  assign load_use_o    = load_use;
  assign pc_write_o    = !(load_use || mem_stall_i);
  assign ifid_write_o  = !(load_use || mem_stall_i);
  assign ifid_flush_o  = flush_i && !load_use && !mem_stall_i;
  assign idex_bubble_o = bubble;

  // Select what enters ID/EX: the decoded fields or an all-zero bubble.
  always_comb begin
    idex_next = '0;
    if (!bubble) begin
      idex_next.rs1      = id_rs1_i;
      idex_next.rs2      = id_rs2_i;
      idex_next.rd       = id_rd_i;
      idex_next.regwrite = id_regwrite_i;
      idex_next.memread  = id_memread_i;
    end
  end

  // Shadow pipeline advance; everything holds while the cache is missing.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idex_reg  <= '0;
      exmem_reg <= '0;
      memwb_reg <= '0;
    end else if (!mem_stall_i) begin
      memwb_reg.rd       <= exmem_reg.rd;
      memwb_reg.regwrite <= exmem_reg.regwrite;
      exmem_reg.rd       <= idex_reg.rd;
      exmem_reg.regwrite <= idex_reg.regwrite;
      exmem_reg.memread  <= idex_reg.memread;
      idex_reg           <= idex_next;
    end
  end

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs             (idex_reg.rs1),
    .exmem_rd       (exmem_reg.rd),
    .exmem_regwrite (exmem_reg.regwrite),
    .memwb_rd       (memwb_reg.rd),
    .memwb_regwrite (memwb_reg.regwrite),
    .sel            (fwd_a_o)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs             (idex_reg.rs2),
    .exmem_rd       (exmem_reg.rd),
    .exmem_regwrite (exmem_reg.regwrite),
    .memwb_rd       (memwb_reg.rd),
    .memwb_regwrite (memwb_reg.regwrite),
    .sel            (fwd_b_o)
  );

endmodule
